// File: rtl/intt16_pointwise_loader_if.sv
// Handshake and frame bus between the coefficient source,
// the pointwise loader and the downstream 16-point INTT.
interface intt16_pointwise_loader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  flush;
    logic                  frame_valid;
    logic                  frame_ack;
    logic [DATA_WIDTH-1:0] out0, out1, out2, out3;
    logic [DATA_WIDTH-1:0] out4, out5, out6, out7;
    logic [DATA_WIDTH-1:0] out8, out9, out10, out11;
    logic [DATA_WIDTH-1:0] out12, out13, out14, out15;
    logic [3:0]            fill_idx;
    logic [7:0]            frame_count;

    modport master (
        output in_valid, in_a, in_b, flush, frame_ack,
        input  in_ready, frame_valid, fill_idx, frame_count,
        input  out0, out1, out2, out3, out4, out5, out6, out7,
        input  out8, out9, out10, out11, out12, out13, out14, out15
    );

    modport slave (
        input  in_valid, in_a, in_b, flush, frame_ack,
        output in_ready, frame_valid, fill_idx, frame_count,
        output out0, out1, out2, out3, out4, out5, out6, out7,
        output out8, out9, out10, out11, out12, out13, out14, out15
    );
endinterface

// File: rtl/intt16_pointwise_loader.sv
// Pointwise (a*b) mod MODULUS loader that assembles
// 16-coefficient frames for the inverse NTT.
module intt16_pointwise_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int MODULUS    = 17,
    parameter int N          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    intt16_pointwise_loader_if.slave      bus
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [PW-1:0] MOD_W = PW'(MODULUS);

    typedef enum logic {FILL, FULL} state_t;

    state_t                state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  wr_en;
    logic [PW-1:0]         prod;
    logic [DATA_WIDTH-1:0] product;
    logic [DATA_WIDTH-1:0] slot_q [N];

    // Full-width product; the remainder always fits in DATA_WIDTH
    assign prod    = {{DATA_WIDTH{1'b0}}, bus.in_a}
                   * {{DATA_WIDTH{1'b0}}, bus.in_b};
    assign product = DATA_WIDTH'(prod % MOD_W);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        if (bus.flush) begin
            state_d = FILL;
            idx_d   = 4'd0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (bus.in_valid) begin
                        wr_en = 1'b1;
                        idx_d = idx_q + 4'd1;
                        if (idx_q == 4'd15) state_d = FULL;
                    end
                end
                FULL: begin
                    if (bus.frame_ack) begin
                        state_d = FILL;
                        idx_d   = 4'd0;
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= 4'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) slot_q[k] <= '0;
        end else if (wr_en) begin
            slot_q[idx_q] <= product;
        end
    end

    assign bus.in_ready    = (state_q == FILL);
    assign bus.frame_valid = (state_q == FULL);
    assign bus.fill_idx    = idx_q;
    assign bus.frame_count = cnt_q;

    assign bus.out0  = slot_q[0];
    assign bus.out1  = slot_q[1];
    assign bus.out2  = slot_q[2];
    assign bus.out3  = slot_q[3];
    assign bus.out4  = slot_q[4];
    assign bus.out5  = slot_q[5];
    assign bus.out6  = slot_q[6];
    assign bus.out7  = slot_q[7];
    assign bus.out8  = slot_q[8];
    assign bus.out9  = slot_q[9];
    assign bus.out10 = slot_q[10];
    assign bus.out11 = slot_q[11];
    assign bus.out12 = slot_q[12];
    assign bus.out13 = slot_q[13];
    assign bus.out14 = slot_q[14];
    assign bus.out15 = slot_q[15];
endmodule

// File: tb/tb_intt16_pointwise_loader.sv
// Directed and randomised checks of the pointwise loader
// against a mod-17 reference model.
module tb_intt16_pointwise_loader;
    logic clk;
    logic rst;

    intt16_pointwise_loader_if #(.DATA_WIDTH(16)) bus ();

    intt16_pointwise_loader #(
        .DATA_WIDTH(16),
        .MODULUS(17),
        .N(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] outs [16];
    assign outs[0]  = bus.out0;
    assign outs[1]  = bus.out1;
    assign outs[2]  = bus.out2;
    assign outs[3]  = bus.out3;
    assign outs[4]  = bus.out4;
    assign outs[5]  = bus.out5;
    assign outs[6]  = bus.out6;
    assign outs[7]  = bus.out7;
    assign outs[8]  = bus.out8;
    assign outs[9]  = bus.out9;
    assign outs[10] = bus.out10;
    assign outs[11] = bus.out11;
    assign outs[12] = bus.out12;
    assign outs[13] = bus.out13;
    assign outs[14] = bus.out14;
    assign outs[15] = bus.out15;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t        tbl [8];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_slot [16];
    int          exp_idx = 0;
    int          exp_cnt = 0;

    function automatic logic [15:0] mod_mul(logic [15:0] a, logic [15:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return 16'(p % 17);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_frame(input string tag);
        for (int k = 0; k < 16; k++)
            check($sformatf("%s out%0d", tag, k), 32'(outs[k]),
                  32'(exp_slot[k]));
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input int gap);
        int t;
        t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            check("in_ready timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            bus.in_valid = 1'b1;
            bus.in_a     = a;
            bus.in_b     = b;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            exp_slot[exp_idx] = mod_mul(a, b);
            exp_idx = (exp_idx + 1) % 16;
            check("fill_idx after accept", 32'(bus.fill_idx), 32'(exp_idx));
        end
    endtask

    task automatic ack();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.frame_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_ack = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        exp_idx = 0;
        check("frame_count after ack", 32'(bus.frame_count), 32'(exp_cnt));
        check("in_ready after ack", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        tbl[0] = '{16'd65535, 16'd65535, 16'd0};
        tbl[1] = '{16'd100,   16'd200,   16'd8};
        tbl[2] = '{16'd16,    16'd16,    16'd1};
        tbl[3] = '{16'd0,     16'd12345, 16'd0};
        tbl[4] = '{16'd65534, 16'd2,     16'd15};
        tbl[5] = '{16'd12,    16'd13,    16'd3};
        tbl[6] = '{16'd17,    16'd3,     16'd0};
        tbl[7] = '{16'd1,     16'd1,     16'd1};

        for (int k = 0; k < 16; k++) exp_slot[k] = '0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.flush = 1'b0;
        bus.frame_ack = 1'b0;
        #12 rst = 1'b0;
        @(negedge clk);

        check("reset fill_idx", 32'(bus.fill_idx), 32'd0);
        check("reset frame_valid", 32'(bus.frame_valid), 32'd0);
        check("reset frame_count", 32'(bus.frame_count), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check_frame("reset");

        // Basic frame: a=i, b=2
        for (int i = 0; i < 16; i++) begin
            send(16'(i), 16'd2, 0);
            if (i == 14)
                check("frame_valid before 16th", 32'(bus.frame_valid), 32'd0);
        end
        check("basic frame_valid", 32'(bus.frame_valid), 32'd1);
        check("basic in_ready", 32'(bus.in_ready), 32'd0);
        check("basic out0", 32'(bus.out0), 32'd0);
        check("basic out8", 32'(bus.out8), 32'd16);
        check("basic out9", 32'(bus.out9), 32'd1);
        check("basic out15", 32'(bus.out15), 32'd13);
        check_frame("basic");

        // Backpressure: input offered while FULL must be stalled
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a = 16'd5;
        bus.in_b = 16'd5;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall fill_idx", 32'(bus.fill_idx), 32'd0);
            check("stall frame_valid", 32'(bus.frame_valid), 32'd1);
            check("stall in_ready", 32'(bus.in_ready), 32'd0);
        end
        check_frame("stall");
        bus.frame_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_ack = 1'b0;
        exp_cnt = 1;
        check("ack frame_count", 32'(bus.frame_count), 32'd1);
        check("ack in_ready", 32'(bus.in_ready), 32'd1);
        check("ack out0 held", 32'(bus.out0), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("first accept out0", 32'(bus.out0), 32'd8);
        check("first accept fill_idx", 32'(bus.fill_idx), 32'd1);
        exp_slot[0] = 16'd8;
        exp_idx = 1;

        // Reduction edge vectors into slots 1..8
        for (int t = 0; t < 8; t++) begin
            send(tbl[t].a, tbl[t].b, 0);
            check($sformatf("vec%0d slot", t), 32'(outs[t + 1]),
                  32'(tbl[t].exp));
        end

        // Idle flush returns fill_idx to 0
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        exp_idx = 0;
        check("flush fill_idx", 32'(bus.fill_idx), 32'd0);
        check("flush frame_count", 32'(bus.frame_count), 32'(exp_cnt));

        // Five pairs, then flush colliding with a valid pair
        for (int i = 0; i < 5; i++)
            send(16'(2 * i + 3), 16'(2 * i + 4), 0);
        @(negedge clk);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_a = 16'd7;
        bus.in_b = 16'd7;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        exp_idx = 0;
        check("flush+valid fill_idx", 32'(bus.fill_idx), 32'd0);
        check("flush+valid out5", 32'(bus.out5), 32'd15);
        check("flush+valid frame_count", 32'(bus.frame_count), 32'(exp_cnt));
        check_frame("flush");

        for (int i = 0; i < 16; i++)
            send(16'(i * 37 + 1), 16'(i + 3), 0);
        check("post-flush frame_valid", 32'(bus.frame_valid), 32'd1);
        check_frame("post-flush");

        // Flush beats a simultaneous ack
        @(negedge clk);
        bus.flush = 1'b1;
        bus.frame_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.frame_ack = 1'b0;
        exp_idx = 0;
        check("flush+ack frame_count", 32'(bus.frame_count), 32'(exp_cnt));
        check("flush+ack frame_valid", 32'(bus.frame_valid), 32'd0);
        check("flush+ack in_ready", 32'(bus.in_ready), 32'd1);

        // Ack in FILL is ignored
        send(16'd9, 16'd9, 0);
        @(negedge clk);
        bus.frame_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_ack = 1'b0;
        check("fill ack frame_count", 32'(bus.frame_count), 32'(exp_cnt));
        check("fill ack fill_idx", 32'(bus.fill_idx), 32'd1);

        // Async reset mid-frame
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        exp_idx = 0;
        for (int i = 0; i < 7; i++)
            send(16'(i + 1), 16'(i + 2), 0);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) exp_slot[k] = '0;
        exp_idx = 0;
        exp_cnt = 0;
        check("async fill_idx", 32'(bus.fill_idx), 32'd0);
        check("async frame_valid", 32'(bus.frame_valid), 32'd0);
        check("async frame_count", 32'(bus.frame_count), 32'd0);
        check_frame("async");
        #3 rst = 1'b0;
        for (int i = 0; i < 16; i++)
            send(16'(1000 + 77 * i), 16'(500 - 13 * i), 0);
        check("fresh frame_valid", 32'(bus.frame_valid), 32'd1);
        check_frame("fresh");
        ack();

        // Random regression
        for (int f = 0; f < 300; f++) begin
            for (int i = 0; i < 16; i++)
                send(16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
            begin
                int d;
                d = int'($urandom_range(0, 3));
                @(negedge clk);
                bus.in_valid = 1'b1;
                bus.in_a = 16'($urandom);
                bus.in_b = 16'($urandom);
                repeat (d) @(negedge clk);
                check("rand frame_valid", 32'(bus.frame_valid), 32'd1);
                check("rand in_ready", 32'(bus.in_ready), 32'd0);
                check_frame($sformatf("rand%0d", f));
            end
            ack();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
